// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,  // post-reset, no request yet
        REQ  = 2'd1,  // request outstanding on the instruction-memory port
        HOLD = 2'd2   // fetched word parked while ID is stalled
    } fetch_state_e;

    // Defaults for the top-level parameters.
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Sequential PC step; the adder wraps modulo 2^32.
    localparam logic [31:0] PC_INC = 32'd4;

    // Every PC load is word aligned: the two low bits are forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/acknowledge port of the fetch stage.
interface instruction_fetch_unit_if;

    logic        imem_req;    // fetch request
    logic [31:0] imem_addr;   // fetch address, stable until acknowledged
    logic        imem_ack;    // imem_rdata valid (may coincide with imem_req)
    logic [31:0] imem_rdata;  // fetched instruction word

    // The fetch unit drives the request side.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // The instruction memory answers it.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instruction_fetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pcplus4_in,
    output logic [31:0] instruction,
    output logic [31:0] pcplus4,
    output logic        valid
);

    // IF/ID contents; a flush inserts a bubble even while stalled.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= NOP_INSTR;
            pcplus4     <= '0;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= NOP_INSTR;
            pcplus4     <= '0;
            valid       <= 1'b0;
        end else if (!stall && load) begin
            instruction <= instr_in;
            pcplus4     <= pcplus4_in;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, instruction-memory handshake, one-entry hold
// buffer for words returned during an ID stall, and the IF/ID register.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // Redirect and hazard control from the ID stage
    input  logic [31:0]                pc_addr,
    input  logic                       pcsrc,
    input  logic                       IFID_flush,
    input  logic                       IFID_stall,
    // Instruction-memory port
    instruction_fetch_unit_if.master   imem,
    // IF/ID outputs
    output logic [31:0]                ID_instruction,
    output logic [31:0]                ID_pcplus4,
    output logic                       ID_valid
);

    fetch_state_e state, state_n;

    logic [31:0] pc, pc_n;
    logic [31:0] redir_pc, redir_pc_n;
    logic        redir_pending, redir_pending_n;
    logic [31:0] hold_instr, hold_instr_n;

    logic        redir;
    logic [31:0] pc_plus4;
    logic        ifid_load;
    logic [31:0] ifid_instr_in;

    // A redirect is only honoured when the hazard unit is not stalling.
    assign redir    = pcsrc & ~IFID_stall;
    assign pc_plus4 = pc + PC_INC;

    // The request is a pure function of state so reset drops it at once.
    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = pc;

    // State registers: PC, pending redirect, hold buffer and FSM state.
    // NOTE: hold_instr is a single control-adjacent register, so it is reset
    // with everything else; wide storage arrays would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            redir_pc      <= '0;
            redir_pending <= 1'b0;
            hold_instr    <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            redir_pc      <= redir_pc_n;
            redir_pending <= redir_pending_n;
            hold_instr    <= hold_instr_n;
        end
    end

    // Next-state logic for the fetch sequencer and the IF/ID load strobe.
    // NOTE: every output of this block gets a default first, otherwise paths
    // that do not assign it would infer latches.
    always_comb begin
        state_n         = state;
        pc_n            = pc;
        redir_pc_n      = redir_pc;
        redir_pending_n = redir_pending;
        hold_instr_n    = hold_instr;
        ifid_load       = 1'b0;
        ifid_instr_in   = imem.imem_rdata;

        unique case (state)
            IDLE: begin
                // First request goes out in the cycle after leaving IDLE.
                state_n = REQ;
                if (redir) begin
                    pc_n = align_pc(pc_addr);
                end
            end

            REQ: begin
                if (imem.imem_ack) begin
                    if (redir || redir_pending) begin
                        // Stale word: drop it and restart at the redirect target.
                        pc_n            = redir ? align_pc(pc_addr) : redir_pc;
                        redir_pending_n = 1'b0;
                    end else if (!IFID_stall) begin
                        // Zero-bubble path: hand the word straight to IF/ID.
                        ifid_load = 1'b1;
                        pc_n      = align_pc(pc_plus4);
                    end else begin
                        // ID cannot take it yet: park the word, keep the PC.
                        hold_instr_n = imem.imem_rdata;
                        state_n      = HOLD;
                    end
                end else if (redir) begin
                    // Keep the address stable until the ack; remember the target.
                    redir_pc_n      = align_pc(pc_addr);
                    redir_pending_n = 1'b1;
                end
            end

            HOLD: begin
                if (!IFID_stall) begin
                    state_n = REQ;
                    if (redir) begin
                        // Parked word belongs to the wrong path; discard it.
                        pc_n = align_pc(pc_addr);
                    end else begin
                        ifid_load     = 1'b1;
                        ifid_instr_in = hold_instr;
                        pc_n          = align_pc(pc_plus4);
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ifid_load),
        .stall       (IFID_stall),
        .flush       (IFID_flush),
        .instr_in    (ifid_instr_in),
        .pcplus4_in  (pc_plus4),
        .instruction (ID_instruction),
        .pcplus4     (ID_pcplus4),
        .valid       (ID_valid)
    );

endmodule
